// File: rtl/line_buffer_pkg.sv
// Shared types for the 7-row line buffer.
// Holds pixel width, window height and FSM state encoding.
package line_buffer_pkg;

   localparam int PIX_W = 8;
   localparam int WIN_H = 7;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } lb_state_e;

endpackage

// File: rtl/line_buffer_7x7_if.sv
// Pixel-in / column-out bundle of the 7-row line buffer.
// master drives pixels, slave produces the column taps.
interface line_buffer_7x7_if;
   import line_buffer_pkg::*;

   logic   done_i;
   pixel_t data_i;
   pixel_t s_o [WIN_H];
   logic   done_o;
   logic   progress_done_o;

   modport master (
      output done_i, data_i,
      input  s_o, done_o, progress_done_o
   );

   modport slave (
      input  done_i, data_i,
      output s_o, done_o, progress_done_o
   );

endinterface

// File: rtl/line_buffer_7x7_fifo.sv
// One image-row delay line: DEPTH-stage shift register.
// Contents are not reset; the parent masks stale data.
module line_fifo
   import line_buffer_pkg::*;
#(
   parameter int DEPTH = 9
) (
   input  logic   clk,
   input  logic   en,
   input  pixel_t d,
   output pixel_t q
);

   pixel_t mem_q [DEPTH];
   pixel_t mem_d [DEPTH];

   // shift one stage toward the tail when a pixel is accepted
   always_comb begin
      mem_d = mem_q;
      if (en) begin
         mem_d[0] = d;
         for (int i = 1; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i-1];
         end
      end
   end

   // storage register, no reset needed
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign q = mem_q[DEPTH-1];

endmodule

// File: rtl/line_buffer_7x7.sv
// Seven-row line buffer feeding a 7x7 window buffer.
// Define LINE_BUFFER_ZERO_PAD_EN to emit zero-padded columns from row 0.
module line_buffer_7x7
   import line_buffer_pkg::*;
#(
   parameter int COLS = 9,
   parameter int ROWS = 9
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   done_i,
   input  pixel_t data_i,
   output pixel_t S1_o,
   output pixel_t S2_o,
   output pixel_t S3_o,
   output pixel_t S4_o,
   output pixel_t S5_o,
   output pixel_t S6_o,
   output pixel_t S7_o,
   output logic   done_o,
   output logic   progress_done_o
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int NL = WIN_H - 1;

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   lb_state_e     state_q, state_d;
   pixel_t        s_q [WIN_H];
   pixel_t        s_d [WIN_H];
   logic          done_q, done_d;
   logic          prog_q, prog_d;

   pixel_t fifo_in  [NL];
   pixel_t fifo_out [NL];
   pixel_t tap      [WIN_H];

   logic col_last;
   logic row_last;
   logic frame_end;
   logic row6_start;

   // six delay lines in series; tap[0] is the oldest row
   for (genvar g = 0; g < NL; g++) begin : g_line
      if (g == 0) begin : g_head
         assign fifo_in[g] = data_i;
      end else begin : g_link
         assign fifo_in[g] = fifo_out[g-1];
      end
      line_fifo #(
         .DEPTH (COLS)
      ) u_fifo (
         .clk (clk),
         .en  (done_i),
         .d   (fifo_in[g]),
         .q   (fifo_out[g])
      );
      assign tap[NL-1-g] = fifo_out[g];
   end
   assign tap[WIN_H-1] = data_i;

   assign col_last   = (col_q == CW'(COLS - 1));
   assign row_last   = (row_q == RW'(ROWS - 1));
   assign frame_end  = done_i && col_last && row_last;
   assign row6_start = (row_q == RW'(NL)) && (col_q == '0);

   // raster position counters, advancing on accepted pixels
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (done_i) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // frame phase: filling, streaming, or emitting the last column
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_FILL: begin
            if (frame_end) begin
               state_d = ST_FLUSH;
            end else if (done_i && row6_start) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (frame_end) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            state_d = ST_FILL;
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

`ifdef LINE_BUFFER_ZERO_PAD_EN
   // every pixel emits a column; rows above the frame read as zero
   always_comb begin
      s_d    = s_q;
      done_d = 1'b0;
      prog_d = 1'b0;
      if (done_i) begin
         done_d = 1'b1;
         prog_d = frame_end;
         for (int k = 0; k < WIN_H; k++) begin
            s_d[k] = (int'(row_q) >= NL - k) ? tap[k] : '0;
         end
      end
   end
`else
   logic stream_px;
   assign stream_px = (state_q == ST_STREAM) || row6_start;

   // emit a column only once six full rows are buffered
   always_comb begin
      s_d    = s_q;
      done_d = 1'b0;
      prog_d = 1'b0;
      if (done_i && stream_px) begin
         done_d = 1'b1;
         prog_d = frame_end;
         for (int k = 0; k < WIN_H; k++) begin
            s_d[k] = tap[k];
         end
      end
   end
`endif

   // control and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q   <= '0;
         row_q   <= '0;
         state_q <= ST_FILL;
         done_q  <= 1'b0;
         prog_q  <= 1'b0;
         for (int k = 0; k < WIN_H; k++) begin
            s_q[k] <= '0;
         end
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         state_q <= state_d;
         done_q  <= done_d;
         prog_q  <= prog_d;
         s_q     <= s_d;
      end
   end

   assign S1_o            = s_q[0];
   assign S2_o            = s_q[1];
   assign S3_o            = s_q[2];
   assign S4_o            = s_q[3];
   assign S5_o            = s_q[4];
   assign S6_o            = s_q[5];
   assign S7_o            = s_q[6];
   assign done_o          = done_q;
   assign progress_done_o = prog_q;

endmodule

// File: tb/tb_line_buffer_7x7.sv
// Bench for line_buffer_7x7 (9x9 frames).
// Reference model indexes a stored frame by raster position.
module tb_line_buffer_7x7;
   import line_buffer_pkg::*;

   localparam int COLS = 9;
   localparam int ROWS = 9;
   localparam int NPIX = COLS * ROWS;
`ifdef LINE_BUFFER_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   localparam int PULSES = PAD ? NPIX : (ROWS - 6) * COLS;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   line_buffer_7x7_if bus ();

   line_buffer_7x7 #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .done_i          (bus.done_i),
      .data_i          (bus.data_i),
      .S1_o            (bus.s_o[0]),
      .S2_o            (bus.s_o[1]),
      .S3_o            (bus.s_o[2]),
      .S4_o            (bus.s_o[3]),
      .S5_o            (bus.s_o[4]),
      .S6_o            (bus.s_o[5]),
      .S7_o            (bus.s_o[6]),
      .done_o          (bus.done_o),
      .progress_done_o (bus.progress_done_o)
   );

   int total = 0;
   int bad   = 0;
   int frame [NPIX];
   int pos;
   int exp_s [7];
   bit exp_done;
   bit exp_prog;
   int n_done;
   int n_prog;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      chk("done_o", 32'(bus.done_o), 32'(exp_done));
      chk("progress", 32'(bus.progress_done_o), 32'(exp_prog));
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("S%0d_o", k + 1), 32'(bus.s_o[k]), exp_s[k]);
      end
      n_done += int'(bus.done_o);
      n_prog += int'(bus.progress_done_o);
   endtask

   task automatic step(bit v, logic [7:0] d);
      int r;
      int idx;
      bus.done_i = v;
      bus.data_i = d;
      exp_done   = 1'b0;
      exp_prog   = 1'b0;
      if (v) begin
         frame[pos] = int'(d);
         r = pos / COLS;
         if (PAD || r >= 6) begin
            exp_done = 1'b1;
            exp_prog = (pos == NPIX - 1);
            for (int k = 0; k < 7; k++) begin
               idx = pos - (6 - k) * COLS;
               exp_s[k] = (idx >= 0) ? frame[idx] : 0;
            end
         end
         pos = (pos + 1) % NPIX;
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.done_i = 1'b0;
      rst = 1'b0;
      #2;
      chk("rst_done", 32'(bus.done_o), 0);
      chk("rst_prog", 32'(bus.progress_done_o), 0);
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("rst_S%0d", k + 1), 32'(bus.s_o[k]), 0);
         exp_s[k] = 0;
      end
      pos = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst        = 1'b1;
      bus.done_i = 1'b0;
      bus.data_i = '0;
      pos        = 0;
      for (int k = 0; k < 7; k++) exp_s[k] = 0;
      #7;
      do_reset();

      // basic stream 1..81
      n_done = 0;
      n_prog = 0;
      for (int p = 1; p <= NPIX; p++) begin
         step(1'b1, 8'(p));
         if (p == 55) begin
            chk("first_S1", 32'(bus.s_o[0]), 1);
            chk("first_S7", 32'(bus.s_o[6]), 55);
         end
      end
      chk("last_S1", 32'(bus.s_o[0]), 27);
      chk("last_prog", 32'(bus.progress_done_o), 1);
      step(1'b0, 8'd0);
      chk("basic_pulses", n_done, PULSES);
      chk("basic_prog", n_prog, 1);

      // stall after pixel 60
      for (int p = 1; p <= 60; p++) step(1'b1, 8'(p));
      repeat (3) step(1'b0, 8'hAA);
      chk("stall_hold_S7", 32'(bus.s_o[6]), 60);
      step(1'b1, 8'd61);
      chk("stall_S7", 32'(bus.s_o[6]), 61);
      chk("stall_S1", 32'(bus.s_o[0]), 7);
      for (int p = 62; p <= NPIX; p++) step(1'b1, 8'(p));

      // reset mid-frame then a fresh frame
      for (int p = 1; p <= 40; p++) step(1'b1, 8'(p));
      do_reset();
      n_done = 0;
      n_prog = 0;
      for (int p = 1; p <= NPIX; p++) step(1'b1, 8'(p));
      chk("rst_last_S1", 32'(bus.s_o[0]), 27);
      chk("rst_last_S7", 32'(bus.s_o[6]), 81);
      step(1'b0, 8'd0);
      chk("rst_pulses", n_done, PULSES);

      // back-to-back random frames
      n_done = 0;
      n_prog = 0;
      for (int p = 0; p < 2 * NPIX; p++) begin
         step(1'b1, 8'($urandom_range(0, 255)));
      end
      step(1'b0, 8'd0);
      chk("b2b_pulses", n_done, 2 * PULSES);
      chk("b2b_prog", n_prog, 2);

      // random data with random stalls
      n_done = 0;
      n_prog = 0;
      for (int p = 0; p < 2 * NPIX; p++) begin
         while ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom));
         step(1'b1, 8'($urandom_range(0, 255)));
      end
      step(1'b0, 8'd0);
      chk("rnd_pulses", n_done, 2 * PULSES);
      chk("rnd_prog", n_prog, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/line_buffer_7x7.md
LINE_BUFFER_7X7 -- requirements
Module: line_buffer_7x7

Interface
REQ-001 SHALL have parameter COLS, default 9: pixels per image row.
REQ-002 SHALL have parameter ROWS, default 9: rows per frame, with ROWS >= 7.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port done_i, input, 1 bit: pixel valid; data_i is consumed on each cycle it is high.
REQ-006 SHALL have port data_i, input, 8 bits: raster-order pixel.
REQ-007 SHALL have ports S1_o..S7_o, output, 8 bits each: the same column from 7 consecutive rows (S1_o = oldest row r-6, S7_o = current row r).
REQ-008 SHALL have port done_o, output, 1 bit: S1_o..S7_o are valid this cycle (feeds done_i of the 7x7 window buffer).
REQ-009 SHALL have port progress_done_o, output, 1 bit: one-cycle pulse marking that the frame has been fully emitted.

Function
REQ-010 SHALL contain six COLS-deep row delay lines chained serially; each delay line advances only on a cycle where done_i=1.
REQ-011 SHALL keep a column counter (0..COLS-1) and a row counter (0..ROWS-1), both advancing only on accepted pixels; the column wraps at COLS-1 and then increments the row.
REQ-012 SHALL implement the FSM states FILL, STREAM and FLUSH; reset enters FILL.
REQ-013 SHALL remain in FILL while row < 6, with done_o held at 0.
REQ-014 SHALL move from FILL to STREAM on the accepted pixel that starts row 6.
REQ-015 SHALL, in STREAM, register S1_o..S7_o and assert done_o exactly one cycle after each accepted pixel (1-cycle latency).
REQ-016 SHALL move to FLUSH on acceptance of pixel (ROWS-1, COLS-1).
REQ-017 SHALL, in FLUSH, emit the final output with done_o=1 and progress_done_o=1 in the same cycle, then return to FILL with both counters cleared.
REQ-018 SHALL treat done_i=0 as a stall: no counter or delay-line change, done_o=0, and S*_o holding their previous values.
REQ-019 SHALL emit exactly (ROWS-6)*COLS done_o pulses per frame.
REQ-020 SHALL allow back-to-back frames: a pixel accepted in the cycle after the FLUSH transition belongs to the new frame (row 0, column 0).

Reset
REQ-021 SHALL, while rst=0, force S1_o..S7_o=0, done_o=0, progress_done_o=0, both counters=0 and the state to FILL, independent of clk.
REQ-022 SHALL allow delay-line contents to stay uncleared on reset, because FILL gating masks stale data.
REQ-023 SHALL discard a frame interrupted by reset mid-frame; the next accepted pixel is row 0, column 0.

Configuration
REQ-024 SHALL, when macro LINE_BUFFER_ZERO_PAD_EN is defined, assert done_o from row 0, forcing S outputs for rows not yet filled (S1_o..S(6-r)_o for r < 6) to 0; this yields ROWS*COLS done_o pulses per frame.
REQ-025 SHALL, when LINE_BUFFER_ZERO_PAD_EN is undefined, behave exactly as REQ-013..REQ-019 with no padding logic synthesised.

Structure
REQ-026 SHALL place the FSM state encoding, the pixel width (8) and the window height (7) in the shared package line_buffer_pkg.
REQ-027 SHALL implement each row delay line as sub-module line_fifo (parameter DEPTH=COLS, 8-bit, shift-on-enable), instantiated six times.

Verification (COLS=9, ROWS=9; stimulus pixels 1..81 in raster order)
REQ-028 SHALL cover basic stream: done_i=1 continuously for 81 cycles -> the first done_o comes 1 cycle after pixel 55 with S1_o=1, S2_o=10, ..., S7_o=55; the last has S1_o=27, S7_o=81; 27 done_o pulses total.
REQ-029 SHALL cover end of frame: progress_done_o is high for exactly one cycle, coincident with the done_o carrying S7_o=81; 0 otherwise.
REQ-030 SHALL cover stall: done_i=0 for 3 cycles after pixel 60 -> no done_o during the gap, outputs hold S7_o=60, and the next output is S7_o=61, S1_o=7.
REQ-031 SHALL cover reset mid-frame: rst=0 after pixel 40, then a fresh 1..81 stream -> all outputs 0 during reset, and the results are identical to REQ-028.
REQ-032 SHALL cover back-to-back frames: two consecutive 81-pixel frames -> 54 done_o pulses and 2 progress_done_o pulses, with the second frame's first output S1_o=1, S7_o=55.
REQ-033 SHALL cover LINE_BUFFER_ZERO_PAD_EN defined: the first done_o is 1 cycle after pixel 1 with S7_o=1 and S1_o..S6_o=0; 81 done_o pulses total.
